// File: rtl/display_scan_arbiter_pkg.sv
// Shared constants, payload types and digit helpers for the 3-digit display scan arbiter.
package display_scan_arbiter_pkg;

  localparam int unsigned NIB_W   = 4;
  localparam int unsigned VAL_W   = 3 * NIB_W;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned DIG_W   = 2;
  localparam int unsigned OWNER_W = 2;

  localparam logic [SEL_W-1:0] SEL_OFF      = 3'b000;
  localparam logic [SEL_W-1:0] SEL_UNITS    = 3'b001;
  localparam logic [SEL_W-1:0] SEL_TENS     = 3'b010;
  localparam logic [SEL_W-1:0] SEL_HUNDREDS = 3'b100;

  localparam logic [DIG_W-1:0] DIG_UNITS    = 2'd0;
  localparam logic [DIG_W-1:0] DIG_TENS     = 2'd1;
  localparam logic [DIG_W-1:0] DIG_HUNDREDS = 2'd2;

  localparam logic [NIB_W-1:0] BLANK_CODE = 4'hF;

  // Display owner encoding (arbiter state)
  localparam logic [OWNER_W-1:0] OWN_NONE = 2'd0;
  localparam logic [OWNER_W-1:0] OWN_REQ0 = 2'd1;
  localparam logic [OWNER_W-1:0] OWN_REQ1 = 2'd2;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_ON    = 1'b1
  } phase_e;

  typedef struct packed {
    logic [NIB_W-1:0] hundreds;
    logic [NIB_W-1:0] tens;
    logic [NIB_W-1:0] units;
  } bcd3_t;

  function automatic logic [SEL_W-1:0] digit_onehot(input logic [DIG_W-1:0] idx);
    logic [SEL_W-1:0] sel;
    case (idx)
      DIG_UNITS:    sel = SEL_UNITS;
      DIG_TENS:     sel = SEL_TENS;
      DIG_HUNDREDS: sel = SEL_HUNDREDS;
      default:      sel = SEL_OFF;
    endcase
    return sel;
  endfunction

  // Code sent to the 4511: invalid nibbles and suppressed leading zeros become blank
  function automatic logic [NIB_W-1:0] digit_code(input bcd3_t disp,
                                                  input logic [DIG_W-1:0] idx,
                                                  input logic lz);
    logic [NIB_W-1:0] nib;
    logic [NIB_W-1:0] code;
    case (idx)
      DIG_TENS:     nib = disp.tens;
      DIG_HUNDREDS: nib = disp.hundreds;
      default:      nib = disp.units;
    endcase
    code = (nib > 4'd9) ? BLANK_CODE : nib;
    if (lz) begin
      if ((idx == DIG_HUNDREDS) && (disp.hundreds == 4'd0))
        code = BLANK_CODE;
      if ((idx == DIG_TENS) && (disp.tens == 4'd0) && (disp.hundreds == 4'd0))
        code = BLANK_CODE;
    end
    return code;
  endfunction

endpackage

// File: rtl/display_scan_arbiter_if.sv
// Requester-side and display-side signals of the scan arbiter.
interface display_scan_arbiter_if;
  import display_scan_arbiter_pkg::*;

  logic [1:0]       req;
  bcd3_t            val0;
  bcd3_t            val1;
  logic [1:0]       gnt;
  logic [NIB_W-1:0] bcd;
  logic [SEL_W-1:0] digit_sel;
  logic             frame_start;

  modport master (output req, val0, val1,
                  input  gnt, bcd, digit_sel, frame_start);

  modport slave  (input  req, val0, val1,
                  output gnt, bcd, digit_sel, frame_start);

endinterface

// File: rtl/display_scan_arbiter_scan_timer.sv
// Slot prescaler and digit index. Counters hold the cycle currently on the pins;
// phase_c/digit_c/frame_first_c describe the cycle that starts at the next edge.
module display_scan_arbiter_scan_timer
  import display_scan_arbiter_pkg::*;
#(
  parameter int unsigned PRESCALE     = 8192,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  output phase_e           phase_c,
  output logic [DIG_W-1:0] digit_c,
  output logic             slot_end_c,
  output logic             frame_end_c,
  output logic             frame_first_c
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIG_W-1:0] dig_q, dig_d;
  logic             live_q;

  assign slot_end_c  = live_q && (cnt_q == CW'(PRESCALE - 1));
  assign frame_end_c = slot_end_c && (dig_q == DIG_HUNDREDS);

  // The first edge after reset opens frame 1 at slot position 0
  always_comb begin
    cnt_d = cnt_q;
    dig_d = dig_q;
    if (!live_q) begin
      cnt_d = '0;
      dig_d = DIG_UNITS;
    end else if (slot_end_c) begin
      cnt_d = '0;
      dig_d = (dig_q == DIG_HUNDREDS) ? DIG_UNITS : dig_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign phase_c       = (cnt_d < CW'(BLANK_CYCLES)) ? PH_BLANK : PH_ON;
  assign digit_c       = dig_d;
  assign frame_first_c = (cnt_d == '0) && (dig_d == DIG_UNITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dig_q  <= DIG_UNITS;
      live_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dig_q  <= dig_d;
      live_q <= 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_arbiter.sv
// Frame-boundary arbiter for a shared 3-digit multiplexed 7-segment display:
// owner selection with hold limit, per-frame value latch, digit scan and blanking.
module display_scan_arbiter
  import display_scan_arbiter_pkg::*;
#(
  parameter int unsigned PRESCALE     = 8192,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned MAX_HOLD     = 256,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  display_scan_arbiter_if.slave bus
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  phase_e           phase_c;
  logic [DIG_W-1:0] digit_c;
  logic             slot_end_c;
  logic             frame_end_c;
  logic             frame_first_c;
  logic             boundary_c;

  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               hold_sat_c;
  bcd3_t              disp_q, disp_d;

  logic [1:0]       gnt_q, gnt_d;
  logic [NIB_W-1:0] bcd_q, bcd_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             fs_q;

  display_scan_arbiter_scan_timer #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .phase_c       (phase_c),
    .digit_c       (digit_c),
    .slot_end_c    (slot_end_c),
    .frame_end_c   (frame_end_c),
    .frame_first_c (frame_first_c)
  );

  // Decisions are taken only on the last clock of the hundreds slot
  assign boundary_c = slot_end_c & frame_end_c;
  assign hold_sat_c = (hold_q >= HW'(MAX_HOLD));

  // Arbiter next state: owner, hold counter and latched value
  always_comb begin
    owner_d = owner_q;
    hold_d  = hold_q;
    disp_d  = disp_q;
    if (boundary_c) begin
      if ((owner_q == OWN_REQ0) && bus.req[0])
        owner_d = (bus.req[1] && hold_sat_c) ? OWN_REQ1 : OWN_REQ0;
      else if ((owner_q == OWN_REQ1) && bus.req[1])
        owner_d = (bus.req[0] && hold_sat_c) ? OWN_REQ0 : OWN_REQ1;
      else if (bus.req[0])
        owner_d = OWN_REQ0;
      else if (bus.req[1])
        owner_d = OWN_REQ1;
      else
        owner_d = OWN_NONE;

      if (owner_d != owner_q)
        hold_d = '0;
      else if (!hold_sat_c)
        hold_d = hold_q + HW'(1);

      case (owner_d)
        OWN_REQ0: disp_d = bus.val0;
        OWN_REQ1: disp_d = bus.val1;
        default:  disp_d = disp_q;
      endcase
    end
  end

  // Pin values for the cycle that begins at the next edge
  always_comb begin
    gnt_d = 2'b00;
    sel_d = SEL_OFF;
    bcd_d = BLANK_CODE;
    case (owner_d)
      OWN_REQ0: gnt_d = 2'b01;
      OWN_REQ1: gnt_d = 2'b10;
      default:  gnt_d = 2'b00;
    endcase
    if ((owner_d != OWN_NONE) && (phase_c == PH_ON)) begin
      sel_d = digit_onehot(digit_c);
      bcd_d = digit_code(disp_d, digit_c, LZ_BLANK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      hold_q  <= '0;
      disp_q  <= '0;
    end else begin
      owner_q <= owner_d;
      hold_q  <= hold_d;
      disp_q  <= disp_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= 2'b00;
      sel_q <= SEL_OFF;
      bcd_q <= BLANK_CODE;
      fs_q  <= 1'b0;
    end else begin
      gnt_q <= gnt_d;
      sel_q <= sel_d;
      bcd_q <= bcd_d;
      fs_q  <= frame_first_c;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.digit_sel   = sel_q;
  assign bus.bcd         = bcd_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_arbiter.sv
// Self-checking bench: two DUTs (leading-zero blanking on/off) against a frame-level model.
module tb_display_scan_arbiter;
  import display_scan_arbiter_pkg::*;

  localparam int P  = 16;
  localparam int B  = 4;
  localparam int MH = 2;
  localparam int FL = 3 * P;

  logic clk;
  logic rst_n;

  display_scan_arbiter_if bus_a ();
  display_scan_arbiter_if bus_b ();

  assign bus_b.req  = bus_a.req;
  assign bus_b.val0 = bus_a.val0;
  assign bus_b.val1 = bus_a.val1;

  display_scan_arbiter #(.PRESCALE(P), .BLANK_CYCLES(B), .MAX_HOLD(MH), .LZ_BLANK(1'b1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  display_scan_arbiter #(.PRESCALE(P), .BLANK_CYCLES(B), .MAX_HOLD(MH), .LZ_BLANK(1'b0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Frame-level reference state
  int          m_n, m_pos, m_owner, m_hold;
  logic [11:0] m_disp;

  typedef struct {
    logic [11:0] val;
    logic [3:0]  u1, t1, h1;
    logic [3:0]  u0, t0, h0;
  } vec_t;
  vec_t       tbl [8];
  logic [1:0] rot_exp [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_pos = 0; m_owner = -1; m_hold = 0; m_disp = 12'h000;
  endtask

  task automatic model_step(input logic [1:0] r, input logic [11:0] v0, input logic [11:0] v1);
    int nw;
    if (m_n == 0) begin
      m_pos = 0;
    end else begin
      if (m_pos == FL - 1) begin
        if (m_owner >= 0 && r[m_owner]) begin
          nw = (r[1 - m_owner] && m_hold >= MH) ? 1 - m_owner : m_owner;
        end else begin
          nw = r[0] ? 0 : (r[1] ? 1 : -1);
        end
        if (nw != m_owner) m_hold = 0;
        else if (m_hold < MH) m_hold++;
        m_owner = nw;
        if (nw == 0) m_disp = v0;
        else if (nw == 1) m_disp = v1;
      end
      m_pos = (m_pos + 1) % FL;
    end
    m_n++;
  endtask

  // Expected {gnt, digit_sel, bcd, frame_start} for the current model position
  function automatic logic [9:0] model_view(input bit lz);
    int slot, ph, d, h, t, dv;
    logic [1:0] g;
    logic [2:0] s;
    logic [3:0] b;
    slot = m_pos / P;
    ph   = m_pos % P;
    dv   = int'(m_disp);
    g    = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    s    = 3'b000;
    b    = 4'hF;
    if (m_owner >= 0 && ph >= B) begin
      s = 3'(1 << slot);
      d = (dv >> (4 * slot)) & 15;
      h = (dv >> 8) & 15;
      t = (dv >> 4) & 15;
      b = (d > 9) ? 4'hF : 4'(d);
      if (lz && slot == 2 && h == 0) b = 4'hF;
      if (lz && slot == 1 && h == 0 && t == 0) b = 4'hF;
    end
    return {g, s, b, (m_pos == 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(bus_a.req, bus_a.val0, bus_a.val1);
    #1;
    check($sformatf("lz1 pos%0d {gnt,sel,bcd,fs}", m_pos),
          {22'b0, bus_a.gnt, bus_a.digit_sel, bus_a.bcd, bus_a.frame_start},
          {22'b0, model_view(1'b1)});
    check($sformatf("lz0 pos%0d {gnt,sel,bcd,fs}", m_pos),
          {22'b0, bus_b.gnt, bus_b.digit_sel, bus_b.bcd, bus_b.frame_start},
          {22'b0, model_view(1'b0)});
  endtask

  task automatic run_to_pos(input int p);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (m_pos != p && k < 2 * FL);
  endtask

  task automatic expect_out(input string nm, input bit lz, input logic [1:0] g,
                            input logic [2:0] s, input logic [3:0] b);
    if (lz) begin
      check({nm, " lz1 gnt"}, 32'(bus_a.gnt), 32'(g));
      check({nm, " lz1 sel"}, 32'(bus_a.digit_sel), 32'(s));
      check({nm, " lz1 bcd"}, 32'(bus_a.bcd), 32'(b));
    end else begin
      check({nm, " lz0 gnt"}, 32'(bus_b.gnt), 32'(g));
      check({nm, " lz0 sel"}, 32'(bus_b.digit_sel), 32'(s));
      check({nm, " lz0 bcd"}, 32'(bus_b.bcd), 32'(b));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int fs_cnt;
    tbl[0] = '{12'h123, 4'h3, 4'h2, 4'h1, 4'h3, 4'h2, 4'h1};
    tbl[1] = '{12'h007, 4'h7, 4'hF, 4'hF, 4'h7, 4'h0, 4'h0};
    tbl[2] = '{12'h0A5, 4'h5, 4'hF, 4'hF, 4'h5, 4'hF, 4'h0};
    tbl[3] = '{12'h000, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
    tbl[4] = '{12'h905, 4'h5, 4'h0, 4'h9, 4'h5, 4'h0, 4'h9};
    tbl[5] = '{12'hF3C, 4'hF, 4'h3, 4'hF, 4'hF, 4'h3, 4'hF};
    tbl[6] = '{12'h010, 4'h0, 4'h1, 4'hF, 4'h0, 4'h1, 4'h0};
    tbl[7] = '{12'hA00, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF};
    rot_exp = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};

    // Reset values
    rst_n = 1'b0;
    bus_a.req = 2'b00; bus_a.val0 = 12'h000; bus_a.val1 = 12'h000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 1'b1, 2'b00, 3'b000, 4'hF);
    expect_out("reset", 1'b0, 2'b00, 3'b000, 4'hF);
    check("reset frame_start", 32'(bus_a.frame_start), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Idle: three frames with no requester
    fs_cnt = 0;
    repeat (3 * FL) begin
      tick();
      fs_cnt += int'(bus_a.frame_start);
    end
    check("idle frame_start count", 32'(fs_cnt), 32'd3);

    // Digit table with requester 0; mid-frame val change must not show
    bus_a.req = 2'b01;
    for (int i = 0; i < 8; i++) begin
      bus_a.val0 = tbl[i].val;
      run_to_pos(0);
      run_to_pos(2);
      expect_out($sformatf("vec%0d blank", i), 1'b1, 2'b01, 3'b000, 4'hF);
      run_to_pos(10);
      expect_out($sformatf("vec%0d units", i), 1'b1, 2'b01, 3'b001, tbl[i].u1);
      expect_out($sformatf("vec%0d units", i), 1'b0, 2'b01, 3'b001, tbl[i].u0);
      bus_a.val0 = ~tbl[i].val;
      run_to_pos(P + 10);
      expect_out($sformatf("vec%0d tens", i), 1'b1, 2'b01, 3'b010, tbl[i].t1);
      expect_out($sformatf("vec%0d tens", i), 1'b0, 2'b01, 3'b010, tbl[i].t0);
      run_to_pos(2 * P + 10);
      expect_out($sformatf("vec%0d hundreds", i), 1'b1, 2'b01, 3'b100, tbl[i].h1);
      expect_out($sformatf("vec%0d hundreds", i), 1'b0, 2'b01, 3'b100, tbl[i].h0);
      run_to_pos(FL - 1);
    end

    // Both request together from no owner: requester 0 first, then rotation by hold limit
    run_to_pos(20);
    bus_a.req = 2'b00;
    run_to_pos(20);
    check("released gnt", 32'(bus_a.gnt), 32'd0);
    bus_a.req = 2'b11; bus_a.val0 = 12'h123; bus_a.val1 = 12'h456;
    for (int f = 0; f < 8; f++) begin
      run_to_pos(0);
      check($sformatf("rotation frame%0d gnt", f), 32'(bus_a.gnt), 32'(rot_exp[f]));
    end

    // Owner 0 drops mid tens slot: frame completes untorn, then requester 1 takes over
    run_to_pos(P + 10);
    bus_a.req = 2'b10;
    run_to_pos(2 * P + 8);
    expect_out("drop0 hundreds", 1'b1, 2'b01, 3'b100, 4'h1);
    run_to_pos(0);
    check("drop0 boundary gnt", 32'(bus_a.gnt), 32'b10);
    run_to_pos(P + 10);
    bus_a.req = 2'b00;
    run_to_pos(2 * P + 8);
    expect_out("drop1 hundreds", 1'b1, 2'b10, 3'b100, 4'h4);
    run_to_pos(0);
    run_to_pos(B + 1);
    expect_out("drop1 after boundary", 1'b1, 2'b00, 3'b000, 4'hF);

    // Random traffic against the model
    repeat (900) begin
      tick();
      if ($urandom_range(0, 15) == 0) bus_a.req  = 2'($urandom);
      if ($urandom_range(0, 7) == 0)  bus_a.val0 = 12'($urandom);
      if ($urandom_range(0, 7) == 0)  bus_a.val1 = 12'($urandom);
    end

    // Asynchronous reset during the hundreds on phase
    bus_a.req = 2'b01; bus_a.val0 = 12'h321;
    run_to_pos(0);
    run_to_pos(0);
    run_to_pos(2 * P + 8);
    expect_out("pre-reset hundreds", 1'b1, 2'b01, 3'b100, 4'h3);
    #2 rst_n = 1'b0;
    #1;
    expect_out("async reset", 1'b1, 2'b00, 3'b000, 4'hF);
    expect_out("async reset", 1'b0, 2'b00, 3'b000, 4'hF);
    check("async reset frame_start", 32'(bus_a.frame_start), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("restart frame_start", 32'(bus_a.frame_start), 32'd1);
    expect_out("restart units blank", 1'b1, 2'b00, 3'b000, 4'hF);
    run_to_pos(FL - 1);
    check("restart frame1 gnt", 32'(bus_a.gnt), 32'd0);
    run_to_pos(0);
    check("restart frame2 gnt", 32'(bus_a.gnt), 32'b01);
    run_to_pos(10);
    expect_out("restart units on", 1'b1, 2'b01, 3'b001, 4'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
